// File: rtl/nunchuk_responder_if.sv
// Bus-facing signal bundle of the Nunchuk I2C target: line levels, report input and status outputs.
// The slave modport is used by the responder; the master modport by whatever drives the bus.
interface nunchuk_responder_if #(
    parameter int REPORT_BYTES = 6
);
    logic                      scl_in;
    logic                      sda_in;
    logic                      sda_oe;
    logic [8*REPORT_BYTES-1:0] report_data;
    logic [1:0]                init_stage;
    logic                      busy;
    logic [7:0]                reg_ptr;
    logic                      wr_strobe;
    logic [7:0]                wr_data;

    modport slave (
        input  scl_in, sda_in, report_data,
        output sda_oe, init_stage, busy, reg_ptr, wr_strobe, wr_data
    );

    modport master (
        output scl_in, sda_in, report_data,
        input  sda_oe, init_stage, busy, reg_ptr, wr_strobe, wr_data
    );
endinterface

// File: rtl/nunchuk_responder.sv
// I2C target emulating a Nunchuk: init handshake, pointer writes, 6-byte report reads from a snapshot.
// Latency: SYNC_STAGES+1 i2c_clock cycles from a bus edge to the reaction; sda_oe moves only after SCL falls.
// Backpressure: none; always ACKs its own address and writes, master NACK ends a read. NUNCHUK_INIT_GATE_EN: FF reads until init done.
module nunchuk_responder #(
    parameter logic [6:0] DEV_ADDR     = 7'h52,
    parameter int         REPORT_BYTES = 6,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic                i2c_clock,
    input  logic                rst,
    nunchuk_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    state_t                    state_q, state_d;
    logic [SYNC_STAGES-1:0]    scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0]    sda_sync_q, sda_sync_d;
    logic                      scl_prev_q, scl_prev_d;
    logic                      sda_prev_q, sda_prev_d;
    logic [7:0]                shift_q, shift_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic                      ack_drv_q, ack_drv_d;
    logic                      rd_q, rd_d;
    logic                      first_q, first_d;
    logic [8*REPORT_BYTES-1:0] snapshot_q, snapshot_d;
    logic [7:0]                reg_ptr_q, reg_ptr_d;
    logic [1:0]                init_stage_q, init_stage_d;
    logic                      sda_oe_q, sda_oe_d;
    logic                      busy_q, busy_d;
    logic                      wr_strobe_q, wr_strobe_d;
    logic [7:0]                wr_data_q, wr_data_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte, tx_byte, ptr_inc;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};
    // Out-of-range pointers also fall back to 0 on the next read increment.
    assign ptr_inc   = (reg_ptr_q >= 8'(REPORT_BYTES - 1)) ? 8'd0 : reg_ptr_q + 8'd1;

    always_comb begin
        tx_byte = 8'hFF;
        for (int i = 0; i < REPORT_BYTES; i++) begin
            if (reg_ptr_q == 8'(i)) begin
                tx_byte = snapshot_q[8*(REPORT_BYTES-1-i) +: 8];
            end
        end
`ifdef NUNCHUK_INIT_GATE_EN
        if (init_stage_q != 2'd2) begin
            tx_byte = 8'hFF;
        end
`endif
    end

    always_comb begin
        scl_sync_d   = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
        sda_sync_d   = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
        scl_prev_d   = scl_s;
        sda_prev_d   = sda_s;
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        ack_drv_d    = ack_drv_q;
        rd_d         = rd_q;
        first_d      = first_q;
        snapshot_d   = snapshot_q;
        reg_ptr_d    = reg_ptr_q;
        init_stage_d = init_stage_q;
        sda_oe_d     = sda_oe_q;
        wr_strobe_d  = 1'b0;
        wr_data_d    = wr_data_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_d   = ADDR_ACK;
                                ack_drv_d = 1'b0;
                                rd_d      = rx_byte[0];
                                if (rx_byte[0]) begin
                                    snapshot_d = bus.report_data;
                                end
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                // First SCL fall after the byte pulls SDA low; the next one ends the ACK slot.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            sda_oe_d  = 1'b1;
                            ack_drv_d = 1'b1;
                        end else begin
                            ack_drv_d = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == ADDR_ACK && rd_q) begin
                                shift_d  = tx_byte;
                                sda_oe_d = ~tx_byte[7];
                                state_d  = RD_BYTE;
                            end else begin
                                sda_oe_d = 1'b0;
                                first_d  = (state_q == ADDR_ACK);
                                state_d  = WR_BYTE;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            ack_drv_d = 1'b0;
                            state_d   = WR_ACK;
                            if (first_q) begin
                                reg_ptr_d = rx_byte;
                            end else begin
                                wr_strobe_d = 1'b1;
                                wr_data_d   = rx_byte;
                                reg_ptr_d   = reg_ptr_q + 8'd1;
                                if (reg_ptr_q == 8'hF0 && rx_byte == 8'h55 && init_stage_q == 2'd0) begin
                                    init_stage_d = 2'd1;
                                end else if (reg_ptr_q == 8'hFB && rx_byte == 8'h00 && init_stage_q != 2'd0) begin
                                    init_stage_d = 2'd2;
                                end
                            end
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            ack_drv_d = 1'b0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                // ack_drv_q here records that the master ACKed and the next byte is due.
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            reg_ptr_d = ptr_inc;
                            ack_drv_d = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else if (scl_fall && ack_drv_q) begin
                        ack_drv_d = 1'b0;
                        bit_cnt_d = 4'd0;
                        shift_d   = tx_byte;
                        sda_oe_d  = ~tx_byte[7];
                        state_d   = RD_BYTE;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d == ADDR_ACK) || (state_d == WR_BYTE) || (state_d == WR_ACK) ||
                 (state_d == RD_BYTE)  || (state_d == RD_ACK);
    end

    always_ff @(posedge i2c_clock or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 4'd0;
            ack_drv_q    <= 1'b0;
            rd_q         <= 1'b0;
            first_q      <= 1'b0;
            snapshot_q   <= '0;
            reg_ptr_q    <= 8'd0;
            init_stage_q <= 2'd0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_data_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_prev_d;
            sda_prev_q   <= sda_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            ack_drv_q    <= ack_drv_d;
            rd_q         <= rd_d;
            first_q      <= first_d;
            snapshot_q   <= snapshot_d;
            reg_ptr_q    <= reg_ptr_d;
            init_stage_q <= init_stage_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.init_stage = init_stage_q;
    assign bus.busy       = busy_q;
    assign bus.reg_ptr    = reg_ptr_q;
    assign bus.wr_strobe  = wr_strobe_q;
    assign bus.wr_data    = wr_data_q;
endmodule

// File: tb/tb_nunchuk_responder.sv
// Bench for nunchuk_responder: bit-banged I2C master, queue scoreboard for written and read bytes.
// The reference keeps pointer, init stage and report snapshot as plain integers and arrays.
module tb_nunchuk_responder;
    localparam int Q = 4;
`ifdef NUNCHUK_INIT_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic [47:0] report;

    int vectors = 0;
    int errors  = 0;
    int oe_cnt  = 0;
    logic [7:0] exp_wr[$];
    logic [7:0] rd_exp[$];
    logic [7:0] rd_got[$];
    logic [7:0] mon_g, mon_e;

    int m_ptr  = 0;
    int m_init = 0;
    logic [7:0] m_snap[6];

    nunchuk_responder_if #(.REPORT_BYTES(6)) bus ();
    assign bus.scl_in = m_scl;
    assign bus.sda_in = m_sda & ~bus.sda_oe;

    nunchuk_responder #(.DEV_ADDR(7'h52), .REPORT_BYTES(6), .SYNC_STAGES(2)) dut (
        .i2c_clock (clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.sda_oe === 1'b1) oe_cnt++;
        if (bus.wr_strobe === 1'b1) begin
            if (exp_wr.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL wr_unexpected: got strobe with %02h, expected none", bus.wr_data);
            end else begin
                mon_e = exp_wr.pop_front();
                chk("wr_data", {24'd0, bus.wr_data}, {24'd0, mon_e});
            end
        end
        if (rd_got.size() > 0) begin
            mon_g = rd_got.pop_front();
            if (rd_exp.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL rd_unexpected: got %02h, expected none", mon_g);
            end else begin
                mon_e = rd_exp.pop_front();
                chk("rd_byte", {24'd0, mon_g}, {24'd0, mon_e});
            end
        end
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); m_sda = 1'b0; wq(); m_scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq(); m_scl = 1'b1; wq(); m_sda = 1'b1; wq();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wq(); m_scl = 1'b1; wq(); wq(); m_scl = 1'b0; wq();
    endtask

    task automatic read_bit(output logic v);
        m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); v = bus.sda_in; wq(); m_scl = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            d[i] = v;
        end
        write_bit(nack);
    endtask

    function automatic logic [7:0] model_byte();
        if (GATE && m_init != 2) return 8'hFF;
        if (m_ptr >= 6) return 8'hFF;
        return m_snap[m_ptr];
    endfunction

    // Writes pointer byte then n (<=3) data bytes taken MSB-first from data.
    task automatic do_write(input logic [7:0] ptr, input int n, input logic [23:0] data, input bit stop_at_end);
        logic ack;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hA4, ack); chk("wr_addr_ack", {31'd0, ack}, 0);
        write_byte(ptr, ack);   chk("wr_ptr_ack", {31'd0, ack}, 0);
        m_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            d = data[23-8*i -: 8];
            exp_wr.push_back(d);
            if (m_ptr == 8'hF0 && d == 8'h55 && m_init == 0) m_init = 1;
            else if (m_ptr == 8'hFB && d == 8'h00 && m_init >= 1) m_init = 2;
            write_byte(d, ack); chk("wr_data_ack", {31'd0, ack}, 0);
            m_ptr = (m_ptr + 1) % 256;
        end
        if (stop_at_end) begin
            i2c_stop(); wq();
            chk("wr_busy_after_stop", {31'd0, bus.busy}, 0);
        end
        chk("wr_reg_ptr", {24'd0, bus.reg_ptr}, m_ptr);
        chk("wr_init_stage", {30'd0, bus.init_stage}, m_init);
    endtask

    task automatic do_read(input int n, input bit mutate);
        logic ack;
        logic [7:0] d;
        bus.report_data = report;
        i2c_start();
        write_byte(8'hA5, ack); chk("rd_addr_ack", {31'd0, ack}, 0);
        for (int k = 0; k < 6; k++) m_snap[k] = report[8*(5-k) +: 8];
        chk("rd_busy", {31'd0, bus.busy}, 1);
        if (mutate) begin
            report = ~report ^ 48'h0123_4567_89AB;
            bus.report_data = report;
        end
        for (int i = 0; i < n; i++) begin
            rd_exp.push_back(model_byte());
            read_byte(i == n - 1, d);
            rd_got.push_back(d);
            if (i != n - 1) m_ptr = (m_ptr + 1 >= 6) ? 0 : m_ptr + 1;
        end
        chk("rd_sda_released", {31'd0, bus.sda_oe}, 0);
        chk("rd_busy_after_nack", {31'd0, bus.busy}, 0);
        i2c_stop(); wq();
        chk("rd_reg_ptr", {24'd0, bus.reg_ptr}, m_ptr);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic ack;
        int oe_before;
        rst = 1'b1;
        report = 48'h80_7F_12_34_56_03;
        bus.report_data = report;
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", {31'd0, bus.sda_oe}, 0);
        chk("rst_init_stage", {30'd0, bus.init_stage}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_reg_ptr", {24'd0, bus.reg_ptr}, 0);
        chk("rst_wr_strobe", {31'd0, bus.wr_strobe}, 0);
        chk("rst_wr_data", {24'd0, bus.wr_data}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Read before the handshake (FF when gated), then the init handshake, then a real read.
        do_write(8'h00, 0, 24'h0, 1'b1);
        do_read(6, 1'b0);
        do_write(8'hF0, 1, 24'h55_0000, 1'b1);
        do_write(8'hFB, 1, 24'h00_0000, 1'b1);
        do_write(8'h00, 0, 24'h0, 1'b1);
        do_read(6, 1'b0);

        // Wrong address: no ACK, SDA never pulled, not busy.
        oe_before = oe_cnt;
        i2c_start();
        write_byte(8'hA6, ack); chk("bad_addr_nack", {31'd0, ack}, 1);
        chk("bad_addr_busy", {31'd0, bus.busy}, 0);
        write_byte(8'h00, ack); chk("bad_addr_data_nack", {31'd0, ack}, 1);
        i2c_stop(); wq();
        chk("bad_addr_oe_cycles", oe_cnt - oe_before, 0);

        // Snapshot with wrap from pointer 4, then out-of-range pointer.
        do_write(8'h04, 0, 24'h0, 1'b1);
        do_read(4, 1'b1);
        do_write(8'h09, 0, 24'h0, 1'b1);
        do_read(3, 1'b0);

        // STOP after 4 data bits: byte discarded, pointer kept, next address ACKed.
        i2c_start();
        write_byte(8'hA4, ack); chk("mid_addr_ack", {31'd0, ack}, 0);
        write_byte(8'h10, ack); chk("mid_ptr_ack", {31'd0, ack}, 0);
        m_ptr = 8'h10;
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b1);
        i2c_stop(); wq();
        chk("mid_reg_ptr", {24'd0, bus.reg_ptr}, m_ptr);
        chk("mid_busy", {31'd0, bus.busy}, 0);
        i2c_start();
        write_byte(8'hA4, ack); chk("mid_readdr_ack", {31'd0, ack}, 0);
        i2c_stop(); wq();

        // Repeated START from write into read keeps the pointer.
        report = {$urandom, $urandom_range(0, 65535)};
        do_write(8'h02, 0, 24'h0, 1'b0);
        do_read(3, 1'b0);

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write(8'($urandom_range(0, 9)), int'($urandom_range(0, 3)), 24'($urandom), 1'b1);
            end else begin
                report = {$urandom, $urandom_range(0, 65535)};
                do_read(int'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
            end
        end

        // Asynchronous reset while the responder drives a 0 data bit.
        report = 48'h00_11_22_33_44_55;
        bus.report_data = report;
        do_write(8'h00, 0, 24'h0, 1'b1);
        i2c_start();
        write_byte(8'hA5, ack); chk("rst_rd_addr_ack", {31'd0, ack}, 0);
        chk("rst_pre_oe", {31'd0, bus.sda_oe}, 1);
        #2 rst = 1'b1;
        #1 chk("rst_async_oe", {31'd0, bus.sda_oe}, 0);
        chk("rst_async_init", {30'd0, bus.init_stage}, 0);
        @(negedge clk) rst = 1'b0;
        m_init = 0;
        m_ptr  = 0;
        i2c_stop(); wq();
        report = 48'hA1_B2_C3_D4_E5_F6;
        do_write(8'h00, 0, 24'h0, 1'b1);
        do_read(6, 1'b0);

        repeat (8) @(negedge clk);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("rd_queue_drained", rd_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
